// File: rtl/bwt_block_loader.sv
// bwt_block_loader: packs a valid/ready byte stream into fixed-size blocks
// held in two ping-pong banks. Each completed block is presented to the
// merge-sort stage with a one-cycle start pulse. A holdoff counter spaces the
// pulses so the sorter pipeline can drain.
module bwt_block_loader #(
   parameter int                     ELEMENT_NUM = 8,
   parameter int                     ELEMENT_LEN = 8,
   parameter int                     HOLDOFF     = 16,
   parameter logic [ELEMENT_LEN-1:0] PAD_BYTE    = 8'hFF,
   localparam int                    IDX_W       = $clog2(ELEMENT_NUM),
   localparam int                    LEN_W       = IDX_W + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ELEMENT_LEN-1:0] s_data,
   input  logic                   s_valid,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic [ELEMENT_LEN-1:0] data_out [0:ELEMENT_NUM-1],
   output logic [LEN_W-1:0]       len_out,
   output logic                   start,
   output logic                   busy,
   output logic [15:0]            blk_cnt
);

   localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   // Bank storage and per-bank bookkeeping
   logic [ELEMENT_LEN-1:0] r_bank [0:1][0:ELEMENT_NUM-1];
   logic [LEN_W-1:0]       r_bank_len [0:1];
   logic [1:0]             r_bank_full;
   logic                   r_wr_bank;
   logic                   r_rd_bank;
   logic [IDX_W-1:0]       r_wr_idx;
   logic [HO_W-1:0]        r_holdoff_cnt;

   // Output registers
   logic [ELEMENT_LEN-1:0] r_data_out [0:ELEMENT_NUM-1];
   logic [LEN_W-1:0]       r_len_out;
   logic                   r_start;
   logic [15:0]            r_blk_cnt;

   // Combinational controls
   logic                   w_ready;
   logic                   w_xfer;
   logic                   w_close;
   logic                   w_issue;
   logic [ELEMENT_LEN-1:0] w_next_data [0:ELEMENT_NUM-1];

   // The write bank accepts bytes until it is full; no dependence on s_valid.
   assign w_ready = ~r_bank_full[r_wr_bank];
   assign w_xfer  = s_valid & w_ready;
   assign w_close = w_xfer & ((r_wr_idx == IDX_W'(ELEMENT_NUM - 1)) | s_last);
   assign w_issue = r_bank_full[r_rd_bank] & (r_holdoff_cnt == '0);

   // Build the padded block that the read bank will present on issue
   always_comb begin
      // NOTE: every element gets a default before the conditional overrides,
      // so no path leaves a bit unassigned and no latch is inferred.
      w_next_data = '{default: PAD_BYTE};
      for (int k = 0; k < ELEMENT_NUM; k++) begin
         if (LEN_W'(k) < r_bank_len[r_rd_bank]) begin
            w_next_data[k] = r_bank[r_rd_bank][k];
         end
      end
   end

   // Capture accepted bytes into the current write bank
   // NOTE: the bank array carries no reset; stale contents are never read
   // because only slots below bank_len of a full bank reach data_out.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_bank[r_wr_bank][r_wr_idx] <= s_data;
      end
   end

   // Write side: index advance, block close and bank switch
   // NOTE: all state updates use non-blocking assignment so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_bank  <= 1'b0;
         r_wr_idx   <= '0;
         r_bank_len <= '{default: '0};
      end else if (w_xfer) begin
         if (w_close) begin
            r_bank_len[r_wr_bank] <= {1'b0, r_wr_idx} + LEN_W'(1);
            r_wr_bank             <= ~r_wr_bank;
            r_wr_idx              <= '0;
         end else begin
            r_wr_idx <= r_wr_idx + IDX_W'(1);
         end
      end
   end

   // Full flags: close sets the write bank, issue clears the read bank;
   // the two never target the same bank in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank_full <= 2'b00;
      end else begin
         if (w_close) begin
            r_bank_full[r_wr_bank] <= 1'b1;
         end
         if (w_issue) begin
            r_bank_full[r_rd_bank] <= 1'b0;
         end
      end
   end

   // Read side: issue a full bank to the sorter and restart the holdoff
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_bank     <= 1'b0;
         r_holdoff_cnt <= '0;
         r_data_out    <= '{default: '0};
         r_len_out     <= '0;
         r_start       <= 1'b0;
         r_blk_cnt     <= '0;
      end else begin
         r_start <= w_issue;
         if (w_issue) begin
            r_data_out    <= w_next_data;
            r_len_out     <= r_bank_len[r_rd_bank];
            r_rd_bank     <= ~r_rd_bank;
            r_holdoff_cnt <= HO_W'(HOLDOFF - 1);
            r_blk_cnt     <= r_blk_cnt + 16'd1;
         end else if (r_holdoff_cnt != '0) begin
            r_holdoff_cnt <= r_holdoff_cnt - HO_W'(1);
         end
      end
   end

   assign s_ready  = w_ready;
   assign data_out = r_data_out;
   assign len_out  = r_len_out;
   assign start    = r_start;
   assign busy     = (|r_bank_full) | (r_holdoff_cnt != '0);
   assign blk_cnt  = r_blk_cnt;

endmodule
